// File: rtl/bf_pkg.sv
// Shared opcodes, ALU selector values and FSM state encoding for the Brainfuck
// execute controller.
package bf_pkg;
    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_JZ    = 8'h5B;
    localparam logic [7:0] OP_JNZ   = 8'h5D;
    localparam logic [7:0] OP_HALT  = 8'h00;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_SCAN_F, S_SCAN_B, S_OUT, S_IN, S_HALT
    } state_t;
endpackage

// File: rtl/bf_bracket_scan.sv
// Bracket-matching helper: tracks nesting depth and scan direction, and decides
// per scanned byte whether the match is found, the scan fails, and where pc goes.
module bf_bracket_scan
    import bf_pkg::*;
#(
    parameter int PADDR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             load_back,
    input  logic             step,
    input  logic [7:0]       op,
    input  logic [PADDR-1:0] pc,
    output logic             done,
    output logic             fail,
    output logic [PADDR-1:0] next_pc
);
    logic [PADDR:0] depth, depth_nx;
    logic           back;
    logic           at_edge;

    always_comb begin
        depth_nx = depth;
        if (op == OP_JZ)
            depth_nx = back ? depth - 1'b1 : depth + 1'b1;
        else if (op == OP_JNZ)
            depth_nx = back ? depth + 1'b1 : depth - 1'b1;
        at_edge = back ? (pc == '0) : (pc == '1);
        done    = step && (op != OP_HALT) && (depth_nx == '0);
        // A terminator mid-scan, or needing to step past either end, is unmatched.
        fail    = step && ((op == OP_HALT) || (!done && at_edge));
        next_pc = (back && !done) ? pc - 1'b1 : pc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
            back  <= 1'b0;
        end else if (load) begin
            depth <= (PADDR+1)'(1);
            back  <= load_back;
        end else if (step) begin
            depth <= depth_nx;
        end
    end
endmodule

// File: rtl/bf_exec_ctrl.sv
// Brainfuck execute controller: fetches from program ROM, sequences the ALU and
// data RAM, resolves brackets by scanning, and moves I/O bytes via valid/ready.
module bf_exec_ctrl
    import bf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PADDR = 10,
    parameter int DADDR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [PADDR-1:0] prog_addr,
    input  logic [7:0]       prog_data,
    output logic [DADDR-1:0] data_addr,
    input  logic [WIDTH-1:0] data_rdata,
    output logic [WIDTH-1:0] data_wdata,
    output logic             data_we,
    output logic             alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             halted,
    output logic             error
);
    state_t           state, state_nx;
    logic [PADDR-1:0] pc, pc_nx;
    logic [DADDR-1:0] ptr, ptr_nx;
    logic [7:0]       ins;
    logic             op_sub;
    logic             phase, phase_nx;
    logic             err_set;
    logic             scan_load, scan_back, scan_step;
    logic             scan_done, scan_fail;
    logic [PADDR-1:0] scan_pc;
    logic             cell_zero;

    assign prog_addr = pc;
    assign data_addr = ptr;
    assign alu_b     = WIDTH'(1);
    assign cell_zero = (data_rdata == '0);
    // Scan states alternate: phase 0 presents pc to the ROM, phase 1 judges its byte.
    assign scan_step = ((state == S_SCAN_F) || (state == S_SCAN_B)) && phase;

    bf_bracket_scan #(.PADDR(PADDR)) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (scan_load),
        .load_back (scan_back),
        .step      (scan_step),
        .op        (prog_data),
        .pc        (pc),
        .done      (scan_done),
        .fail      (scan_fail),
        .next_pc   (scan_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        ptr_nx    = ptr;
        phase_nx  = 1'b0;
        err_set   = 1'b0;
        scan_load = 1'b0;
        scan_back = 1'b0;
        unique case (state)
            S_IDLE, S_HALT: if (start) begin
                state_nx = S_FETCH;
                pc_nx    = '0;
                ptr_nx   = '0;
            end
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                unique case (prog_data)
                    OP_RIGHT: begin ptr_nx = ptr + 1'b1; pc_nx = pc + 1'b1; state_nx = S_FETCH; end
                    OP_LEFT:  begin ptr_nx = ptr - 1'b1; pc_nx = pc + 1'b1; state_nx = S_FETCH; end
                    OP_INC, OP_DEC, OP_JZ, OP_JNZ: state_nx = S_EXEC;
                    OP_OUT:   state_nx = S_OUT;
                    OP_IN:    state_nx = S_IN;
                    OP_HALT:  state_nx = S_HALT;
                    default:  begin pc_nx = pc + 1'b1; state_nx = S_FETCH; end
                endcase
            end
            S_EXEC: begin
                if (ins == OP_JZ && cell_zero) begin
                    if (pc == '1) begin err_set = 1'b1; state_nx = S_HALT; end
                    else begin scan_load = 1'b1; pc_nx = pc + 1'b1; state_nx = S_SCAN_F; end
                end else if (ins == OP_JNZ && !cell_zero) begin
                    if (pc == '0) begin err_set = 1'b1; state_nx = S_HALT; end
                    else begin
                        scan_load = 1'b1;
                        scan_back = 1'b1;
                        pc_nx     = pc - 1'b1;
                        state_nx  = S_SCAN_B;
                    end
                end else begin
                    pc_nx    = pc + 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_SCAN_F, S_SCAN_B: begin
                if (!phase) phase_nx = 1'b1;
                else if (scan_fail) begin
                    err_set  = 1'b1;
                    state_nx = S_HALT;
                end else begin
                    pc_nx = scan_pc;
                    if (scan_done) state_nx = S_FETCH;
                end
            end
            S_OUT: if (out_ready) begin pc_nx = pc + 1'b1; state_nx = S_FETCH; end
            S_IN:  if (in_valid)  begin pc_nx = pc + 1'b1; state_nx = S_FETCH; end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        data_we    = 1'b0;
        data_wdata = '0;
        alu_op     = ALU_ADD;
        alu_a      = '0;
        out_data   = '0;
        out_valid  = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        unique case (state)
            S_IDLE: busy = 1'b0;
            S_HALT: begin busy = 1'b0; halted = 1'b1; end
            S_EXEC: begin
                alu_a  = data_rdata;
                alu_op = op_sub;
                if (ins == OP_INC || ins == OP_DEC) begin
                    data_we    = 1'b1;
                    data_wdata = alu_out;
                end
            end
            S_OUT: begin out_valid = 1'b1; out_data = data_rdata[7:0]; end
            S_IN: begin
                in_ready   = 1'b1;
                data_we    = in_valid;
                data_wdata = WIDTH'(in_data);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            ptr    <= '0;
            ins    <= '0;
            op_sub <= ALU_ADD;
            phase  <= 1'b0;
            error  <= 1'b0;
        end else begin
            pc    <= pc_nx;
            ptr   <= ptr_nx;
            phase <= phase_nx;
            if (err_set) error <= 1'b1;
            if (state == S_DECODE) begin
                ins    <= prog_data;
                op_sub <= (prog_data == OP_DEC) ? ALU_SUB : ALU_ADD;
            end
        end
    end
endmodule

// File: tb/tb_bf_exec_ctrl.sv
// Self-checking bench for bf_exec_ctrl with ROM/RAM/ALU models and an
// output-beat scoreboard.
module tb_bf_exec_ctrl;
    localparam int WIDTH = 16;
    localparam int PADDR = 6;
    localparam int DADDR = 4;
    localparam int NV    = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [PADDR-1:0] prog_addr;
    logic [7:0]       prog_data = 8'h00;
    logic [DADDR-1:0] data_addr;
    logic [WIDTH-1:0] data_rdata = '0;
    logic [WIDTH-1:0] data_wdata;
    logic             data_we;
    logic             alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready, busy, halted, error;

    logic [7:0]       rom [64];
    logic [WIDTH-1:0] ram [16];
    logic [7:0]       exp_q [$];
    int               checks = 0;
    int               failures = 0;

    typedef struct packed {
        logic [3:0]  i1;
        logic [15:0] v1;
        logic [3:0]  i2;
        logic [15:0] v2;
        logic        err;
        logic [7:0]  cyc;
        logic        has_out;
        logic [7:0]  outb;
    } vec_t;

    vec_t  vecs [NV];
    string progs [NV];

    bf_exec_ctrl #(.WIDTH(WIDTH), .PADDR(PADDR), .DADDR(DADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .data_addr(data_addr), .data_rdata(data_rdata),
        .data_wdata(data_wdata), .data_we(data_we),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    assign alu_out = alu_op ? alu_a - alu_b : alu_a + alu_b;

    always @(posedge clk) begin
        prog_data <= rom[prog_addr];
        if (data_we) ram[data_addr] <= data_wdata;
        data_rdata <= ram[data_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output beats are judged mid-cycle, one per accepting clock.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_beat: got %0h expected no beat", out_data);
            end else begin
                check("out_beat", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        for (int j = 0; j < 16; j++) ram[j] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_prog(input string s);
        for (int j = 0; j < 64; j++) rom[j] = 8'h00;
        for (int j = 0; j < s.len(); j++) rom[j] = s[j];
    endtask

    task automatic start_prog();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(input string name, output int n);
        n = 0;
        while (!halted && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        check({name, "_halted"}, {31'h0, halted}, 32'h1);
    endtask

    task automatic run_vec(input int i);
        int n;
        string nm;
        nm = $sformatf("v%0d", i);
        do_reset();
        load_prog(progs[i]);
        out_ready = 1'b1;
        if (vecs[i].has_out) exp_q.push_back(vecs[i].outb);
        start_prog();
        wait_halt(nm, n);
        check({nm, "_error"}, {31'h0, error}, {31'h0, vecs[i].err});
        check({nm, "_cell_a"}, {16'h0, ram[vecs[i].i1]}, {16'h0, vecs[i].v1});
        check({nm, "_cell_b"}, {16'h0, ram[vecs[i].i2]}, {16'h0, vecs[i].v2});
        if (vecs[i].cyc != 0) check({nm, "_cycles"}, n, {24'h0, vecs[i].cyc});
        check({nm, "_beats_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        progs[0] = "+++";                vecs[0] = '{4'd0, 16'd3, 4'd0, 16'd3, 1'b0, 8'd11, 1'b0, 8'h00};
        progs[1] = "-";                  vecs[1] = '{4'd0, 16'hFFFF, 4'd1, 16'd0, 1'b0, 8'd5, 1'b0, 8'h00};
        progs[2] = "++[>+++<-]>.";       vecs[2] = '{4'd1, 16'd6, 4'd0, 16'd0, 1'b0, 8'd0, 1'b1, 8'h06};
        progs[3] = "[+++]+";             vecs[3] = '{4'd0, 16'd1, 4'd1, 16'd0, 1'b0, 8'd16, 1'b0, 8'h00};
        progs[4] = "<+";                 vecs[4] = '{4'd15, 16'd1, 4'd0, 16'd0, 1'b0, 8'd7, 1'b0, 8'h00};
        progs[5] = "[";                  vecs[5] = '{4'd0, 16'd0, 4'd1, 16'd0, 1'b1, 8'd5, 1'b0, 8'h00};
        progs[6] = "+]";                 vecs[6] = '{4'd0, 16'd1, 4'd1, 16'd0, 1'b1, 8'd8, 1'b0, 8'h00};
        progs[7] = "a+b+";               vecs[7] = '{4'd0, 16'd2, 4'd1, 16'd0, 1'b0, 8'd12, 1'b0, 8'h00};
        progs[8] = "++[>++[>+<-]<-]>>."; vecs[8] = '{4'd2, 16'd4, 4'd0, 16'd0, 1'b0, 8'd0, 1'b1, 8'h04};
        progs[9] = ">>>>>>>>>>>>>>>>+";  vecs[9] = '{4'd0, 16'd1, 4'd1, 16'd0, 1'b0, 8'd0, 1'b0, 8'h00};

        load_prog("");
        for (int j = 0; j < 16; j++) ram[j] = '0;
        #3;
        check("rst_data_we", {31'h0, data_we}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_handshake", {30'h0, out_valid, in_ready}, 32'h0);
        check("rst_addrs", {22'h0, prog_addr, data_addr}, 32'h0);
        check("rst_alu", {15'h0, alu_op, alu_a}, 32'h0);
        check("rst_data_out", {8'h0, out_data, data_wdata}, 32'h0);

        // '-' on zero cell: subtract selected through EXEC, wraps to all ones.
        do_reset();
        load_prog("-");
        start_prog();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sub_exec_we", {31'h0, data_we}, 32'h1);
        check("sub_exec_op", {31'h0, alu_op}, 32'h1);
        check("sub_exec_wdata", {16'h0, data_wdata}, 32'hFFFF);
        wait_halt("sub", n);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset asserted mid-EXEC of '+': write must vanish immediately.
        do_reset();
        load_prog("+");
        start_prog();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_exec_we", {31'h0, data_we}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", {31'h0, data_we}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_wdata", {16'h0, data_wdata}, 32'h0);
        @(posedge clk); #1;
        check("mid_rst_cell", {16'h0, ram[0]}, 32'h0);
        rst_n = 1'b1;

        // ",." with a slow producer and a stalled consumer.
        do_reset();
        load_prog(",.");
        out_ready = 1'b0;
        in_valid  = 1'b0;
        start_prog();
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1 n++; end
        check("echo_in_ready", {31'h0, in_ready}, 32'h1);
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
        check("echo_in_ready_held", {31'h0, in_ready}, 32'h1);
        check("echo_no_we_idle", {31'h0, data_we}, 32'h0);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("echo_in_ready_drop", {31'h0, in_ready}, 32'h0);
        exp_q.push_back(8'hA5);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1 n++; end
        check("echo_out_valid", {31'h0, out_valid}, 32'h1);
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        check("echo_out_valid_held", {31'h0, out_valid}, 32'h1);
        check("echo_out_data_held", {24'h0, out_data}, 32'hA5);
        out_ready = 1'b1;
        wait_halt("echo", n);
        check("echo_beats_left", exp_q.size(), 0);
        check("echo_cell", {16'h0, ram[0]}, 32'h00A5);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
